// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: word and register-address widths for the 6-bit core.
package cpu_pkg;
   localparam int REG_W   = 6;
   localparam int NREGS   = 8;
   localparam int RADDR_W = 3;

   typedef logic [REG_W-1:0]   word_t;
   typedef logic [RADDR_W-1:0] raddr_t;
endpackage

// File: rtl/reg_file_8x6_if.sv
// Register-file access bundle: one write port, two combinational read ports, debug written mask.
interface reg_file_8x6_if;
   import cpu_pkg::*;

   logic               we;
   raddr_t             waddr;
   word_t              wdata;
   raddr_t             raddr_a;
   raddr_t             raddr_b;
   word_t              rdata_a;
   word_t              rdata_b;
   logic [NREGS-1:0]   written;

   modport master (
      output we, waddr, wdata, raddr_a, raddr_b,
      input  rdata_a, rdata_b, written
   );

   modport slave (
      input  we, waddr, wdata, raddr_a, raddr_b,
      output rdata_a, rdata_b, written
   );
endinterface

// File: rtl/reg_file_8x6_reg_word.sv
// Single storage word with synchronous clear (dominant) and load enable.
module reg_word #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (ld)
         q <= d;
   end

endmodule

// File: rtl/reg_file_8x6.sv
// 8x6 architectural register file: two combinational read ports, write bypass,
// optional hardwired-zero R0 and a sticky per-register written mask.
module reg_file_8x6
   import cpu_pkg::*;
#(
   parameter int WIDTH   = REG_W,
   parameter int DEPTH   = NREGS,
   parameter bit ZERO_R0 = 1'b1,
   parameter bit BYPASS  = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   reg_file_8x6_if.slave   bus
);

   logic [WIDTH-1:0]             q [DEPTH];
   logic [DEPTH-1:0]             ld;
   logic [DEPTH-1:0]             written_q;
   logic [WIDTH-1:0][DEPTH-1:0]  col;
   logic [WIDTH-1:0]             raw_a;
   logic [WIDTH-1:0]             raw_b;
   logic                         byp_a;
   logic                         byp_b;
   logic                         zero_a;
   logic                         zero_b;

   // Clear dominates load inside reg_word, so a write in the reset cycle is dropped.
   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      assign ld[i] = bus.we && (bus.waddr == RADDR_W'(i)) && !(ZERO_R0 && (i == 0));

      reg_word #(.WIDTH(WIDTH)) u_word (
         .clk (clk),
         .clr (rst),
         .ld  (ld[i]),
         .d   (bus.wdata),
         .q   (q[i])
      );
   end

   // A write to R0 still sets its mask bit so bring-up can see the attempt.
   always_ff @(posedge clk) begin
      if (rst)
         written_q <= '0;
      else if (bus.we)
         written_q[bus.waddr] <= 1'b1;
   end

   // Transpose stored words into per-bit columns for the bit-sliced 8:1 selects.
   always_comb begin
      col = '0;
      for (int b = 0; b < WIDTH; b++) begin
         for (int i = 0; i < DEPTH; i++) begin
            col[b][i] = q[i][b];
         end
      end
   end

   always_comb begin
      raw_a = '0;
      raw_b = '0;
      for (int b = 0; b < WIDTH; b++) begin
         raw_a[b] = col[b][bus.raddr_a];
         raw_b[b] = col[b][bus.raddr_b];
      end
   end

   assign zero_a = ZERO_R0 && (bus.raddr_a == '0);
   assign zero_b = ZERO_R0 && (bus.raddr_b == '0);
   assign byp_a  = BYPASS && bus.we && !rst && (bus.raddr_a == bus.waddr);
   assign byp_b  = BYPASS && bus.we && !rst && (bus.raddr_b == bus.waddr);

   assign bus.rdata_a = zero_a ? '0 : (byp_a ? bus.wdata : raw_a);
   assign bus.rdata_b = zero_b ? '0 : (byp_b ? bus.wdata : raw_b);
   assign bus.written = written_q;

endmodule

// File: tb/tb_reg_file_8x6.sv
// Self-checking bench for reg_file_8x6: directed plan then random traffic against an array model,
// run on a bypassing instance and a non-bypassing twin fed identical stimulus.
module tb_reg_file_8x6;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [2:0] waddr;
   logic [5:0] wdata;
   logic [2:0] raddr_a;
   logic [2:0] raddr_b;

   int errors = 0;
   int checks = 0;

   logic [5:0] mem [8];
   logic [7:0] wr_mask;

   reg_file_8x6_if bus ();
   reg_file_8x6_if bus_nb ();

   assign bus.we       = we;
   assign bus.waddr    = waddr;
   assign bus.wdata    = wdata;
   assign bus.raddr_a  = raddr_a;
   assign bus.raddr_b  = raddr_b;
   assign bus_nb.we      = we;
   assign bus_nb.waddr   = waddr;
   assign bus_nb.wdata   = wdata;
   assign bus_nb.raddr_a = raddr_a;
   assign bus_nb.raddr_b = raddr_b;

   reg_file_8x6 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   reg_file_8x6 #(.BYPASS(1'b0)) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (bus_nb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [5:0] ref_rd(input logic [2:0] a, input bit byp);
      if (a == 3'd0)
         return 6'd0;
      if (byp && we && !rst && (a == waddr))
         return wdata;
      return mem[a];
   endfunction

   // Drive one cycle: check reads before the edge, clock, update model, check mask after.
   task automatic step(input string tag, input logic r, input logic w, input logic [2:0] wa,
                       input logic [5:0] wd, input logic [2:0] ra, input logic [2:0] rb);
      rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
      #2;
      chk({tag, ":a"},    {2'b00, bus.rdata_a},    {2'b00, ref_rd(ra, 1'b1)});
      chk({tag, ":b"},    {2'b00, bus.rdata_b},    {2'b00, ref_rd(rb, 1'b1)});
      chk({tag, ":nb_a"}, {2'b00, bus_nb.rdata_a}, {2'b00, ref_rd(ra, 1'b0)});
      chk({tag, ":nb_b"}, {2'b00, bus_nb.rdata_b}, {2'b00, ref_rd(rb, 1'b0)});
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) mem[i] = 6'd0;
         wr_mask = 8'h00;
      end else if (w) begin
         wr_mask[wa] = 1'b1;
         if (wa != 3'd0) mem[wa] = wd;
      end
      #1;
      chk({tag, ":wr"},    bus.written,    wr_mask);
      chk({tag, ":nb_wr"}, bus_nb.written, wr_mask);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 6'd0;
      wr_mask = 8'h00;
      rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      step("rst_rd", 1'b0, 1'b0, 3'd0, 6'h00, 3'd3, 3'd7);
      chk("rst_a_const", {2'b00, bus.rdata_a}, 8'h00);
      chk("rst_written_const", bus.written, 8'h00);

      // Write R5, R2 then read both
      step("wr5", 1'b0, 1'b1, 3'd5, 6'h2A, 3'd1, 3'd1);
      step("wr2", 1'b0, 1'b1, 3'd2, 6'h15, 3'd1, 3'd1);
      step("rd52", 1'b0, 1'b0, 3'd0, 6'h00, 3'd5, 3'd2);
      raddr_a = 3'd5; raddr_b = 3'd2; #1;
      chk("r5_const", {2'b00, bus.rdata_a}, 8'h2A);
      chk("r2_const", {2'b00, bus.rdata_b}, 8'h15);
      chk("wr_mask_const", bus.written, 8'h24);

      // Sweep i+1 into Ri, then read back
      for (int i = 1; i < 8; i++)
         step("sweep_wr", 1'b0, 1'b1, 3'(i), 6'(i + 1), 3'(i), 3'(7 - i));
      for (int i = 0; i < 8; i++) begin
         step("sweep_rd", 1'b0, 1'b0, 3'd0, 6'h00, 3'(i), 3'(i));
         chk("sweep_const", {2'b00, bus.rdata_a}, (i == 0) ? 8'd0 : 8'(i + 1));
      end

      // R0 hardwired zero
      rst = 1'b0; we = 1'b1; waddr = 3'd0; wdata = 6'h3F; raddr_a = 3'd0; raddr_b = 3'd0;
      #2;
      chk("r0_pre", {2'b00, bus.rdata_a}, 8'h00);
      step("r0_wr", 1'b0, 1'b1, 3'd0, 6'h3F, 3'd0, 3'd0);
      step("r0_post", 1'b0, 1'b0, 3'd0, 6'h00, 3'd0, 3'd0);
      chk("r0_written", {7'd0, bus.written[0]}, 8'h01);

      // Bypass vs no bypass
      step("r4_init", 1'b0, 1'b1, 3'd4, 6'h01, 3'd4, 3'd4);
      we = 1'b1; waddr = 3'd4; wdata = 6'h3C; raddr_a = 3'd4; raddr_b = 3'd1;
      #2;
      chk("byp_pre", {2'b00, bus.rdata_a}, 8'h3C);
      chk("nobyp_pre", {2'b00, bus_nb.rdata_a}, 8'h01);
      step("byp", 1'b0, 1'b1, 3'd4, 6'h3C, 3'd4, 3'd4);
      step("byp_post", 1'b0, 1'b0, 3'd0, 6'h00, 3'd4, 3'd4);
      chk("byp_post_const", {2'b00, bus_nb.rdata_a}, 8'h3C);

      // Reset priority over write
      step("r1_init", 1'b0, 1'b1, 3'd1, 6'h11, 3'd1, 3'd1);
      step("rst_pri", 1'b1, 1'b1, 3'd1, 6'h22, 3'd1, 3'd1);
      step("rst_pri_rd", 1'b0, 1'b0, 3'd0, 6'h00, 3'd1, 3'd5);
      chk("rst_pri_const", {2'b00, bus.rdata_a}, 8'h00);

      // Random traffic
      for (int n = 0; n < 300; n++)
         step("rand", ($urandom_range(0, 24) == 0), 1'($urandom), 3'($urandom),
              6'($urandom), 3'($urandom), 3'($urandom));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
